// File: rtl/gf_alu_pkg.sv
// Shared encodings and helpers for the word-serial gf ALU.
package gf_alu_pkg;

    localparam logic [2:0] OP_NONE  = 3'b000;
    localparam logic [2:0] OP_XOR   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_ARITH = 3'b100;

    typedef enum logic {ST_FIRST = 1'b0, ST_CHAIN = 1'b1} state_t;

    function automatic logic op_is_onehot(input logic [2:0] op);
        return (op == OP_XOR) || (op == OP_AND) || (op == OP_ARITH);
    endfunction

endpackage

// File: rtl/gf_alu_slice.sv
// Combinational WIDTH-bit complement / logic / add core for one slice.
module gf_alu_slice
    import gf_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cmpl_x,
    input  logic             cmpl_y,
    input  logic [2:0]       op,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [WIDTH-1:0] a, b;
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] low;

    assign a    = x ^ {WIDTH{cmpl_x}};
    assign b    = y ^ {WIDTH{cmpl_y}};
    assign full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    // Sum of the lower WIDTH-1 bits; its top bit is the carry into the MSB.
    assign low  = {1'b0, a[WIDTH-2:0]} + {1'b0, b[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, cin};

    always_comb begin
        sum   = '0;
        cout  = 1'b0;
        c_msb = 1'b0;
        case (op)
            OP_XOR:   sum = a ^ b;
            OP_AND:   sum = a & b;
            OP_ARITH: begin
                sum   = full[WIDTH-1:0];
                cout  = full[WIDTH];
                c_msb = low[WIDTH-1];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/gf_alu_n_pipe.sv
// Word-serial gf ALU: stream FSM, inter-slice carry / zero tracking and a
// LAT-deep balanced output pipeline.
module gf_alu_n_pipe
    import gf_alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LAT   = 2
) (
    input  logic             gclk,
    input  logic             rst,
    input  logic             In_valid,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Carry_in,
    input  logic             End,
    input  logic             Cmpl_X,
    input  logic             Cmpl_Y,
    input  logic             Op_XOR,
    input  logic             Op_AND,
    input  logic             Op_ARITH,
    output logic             Out_valid,
    output logic             Out_last,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry_out,
    output logic             Overflow,
    output logic             Zero
);

    typedef struct packed {
        logic             last;
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        logic             zero;
    } res_t;

    state_t           state, state_nxt;
    logic             carry_q, zero_acc;
    logic [2:0]       op_raw, op;
    logic             is_arith, c_sel, zacc_cur, sum_zero;
    logic [WIDTH-1:0] s_sum;
    logic             s_cout, s_cmsb;
    res_t             res;
    logic [LAT:1]     vld_pipe;
    res_t             dat_pipe [1:LAT];

    assign op_raw   = {Op_ARITH, Op_AND, Op_XOR};
    assign op       = op_is_onehot(op_raw) ? op_raw : OP_NONE;
    assign is_arith = (op == OP_ARITH);
    assign c_sel    = (state == ST_FIRST) ? Carry_in : carry_q;
    assign zacc_cur = (state == ST_FIRST) ? 1'b1 : zero_acc;
    assign sum_zero = (s_sum == '0);

    gf_alu_slice #(.WIDTH(WIDTH)) u_slice (
        .x      (X),
        .y      (Y),
        .cmpl_x (Cmpl_X),
        .cmpl_y (Cmpl_Y),
        .op     (op),
        .cin    (c_sel),
        .sum    (s_sum),
        .cout   (s_cout),
        .c_msb  (s_cmsb)
    );

    always_comb begin
        res      = '0;
        res.last = End;
        res.sum  = s_sum;
        res.cout = s_cout;
        res.ovf  = is_arith & End & (s_cmsb ^ s_cout);
        res.zero = End & zacc_cur & sum_zero;
    end

    always_comb begin
        state_nxt = state;
        if (In_valid) state_nxt = End ? ST_FIRST : ST_CHAIN;
    end

    always_ff @(posedge gclk or posedge rst) begin
        if (rst) state <= ST_FIRST;
        else     state <= state_nxt;
    end

    always_ff @(posedge gclk or posedge rst) begin
        if (rst) begin
            carry_q  <= 1'b0;
            zero_acc <= 1'b1;
        end else if (In_valid) begin
            carry_q  <= is_arith & s_cout;
            zero_acc <= End | (zacc_cur & sum_zero);
        end
    end

    // Idle beats enter the pipe as zeros so outputs stay quiet between results.
    always_ff @(posedge gclk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            for (int i = 1; i <= LAT; i++) dat_pipe[i] <= '0;
        end else begin
            vld_pipe[1] <= In_valid;
            dat_pipe[1] <= In_valid ? res : '0;
            for (int i = 2; i <= LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                dat_pipe[i] <= dat_pipe[i-1];
            end
        end
    end

    assign Out_valid = vld_pipe[LAT];
    assign Out_last  = dat_pipe[LAT].last;
    assign Sum       = dat_pipe[LAT].sum;
    assign Carry_out = dat_pipe[LAT].cout;
    assign Overflow  = dat_pipe[LAT].ovf;
    assign Zero      = dat_pipe[LAT].zero;

endmodule

// File: tb/tb_gf_alu_n_pipe.sv
// Bench for gf_alu_n_pipe: arithmetic stream model plus hand-computed vectors.
module tb_gf_alu_n_pipe;

    localparam int WIDTH = 8;
    localparam int LAT   = 2;

    logic             gclk = 1'b0;
    logic             rst  = 1'b0;
    logic             In_valid = 1'b0;
    logic [WIDTH-1:0] X = '0, Y = '0;
    logic             Carry_in = 1'b0, End = 1'b0, Cmpl_X = 1'b0, Cmpl_Y = 1'b0;
    logic             Op_XOR = 1'b0, Op_AND = 1'b0, Op_ARITH = 1'b0;
    logic             Out_valid, Out_last, Carry_out, Overflow, Zero;
    logic [WIDTH-1:0] Sum;

    gf_alu_n_pipe #(.WIDTH(WIDTH), .LAT(LAT)) dut (
        .gclk(gclk), .rst(rst), .In_valid(In_valid), .X(X), .Y(Y),
        .Carry_in(Carry_in), .End(End), .Cmpl_X(Cmpl_X), .Cmpl_Y(Cmpl_Y),
        .Op_XOR(Op_XOR), .Op_AND(Op_AND), .Op_ARITH(Op_ARITH),
        .Out_valid(Out_valid), .Out_last(Out_last), .Sum(Sum),
        .Carry_out(Carry_out), .Overflow(Overflow), .Zero(Zero)
    );

    always #5 gclk = ~gclk;

    typedef struct {
        bit v; bit last; int sum; bit cout; bit ovf; bit zero;
    } obs_t;

    int   checks = 0, errors = 0;
    int   cyc = 0;
    obs_t exp_line [1:LAT];
    obs_t lit [0:1023];
    bit   lit_on [0:1023];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    always @(posedge gclk) cyc <= cyc + 1;

    // Model: streams are multi-word integers; carry is the integer carry,
    // overflow is a signed range check on the top slice.
    bit   m_chain, m_carry, m_zacc;
    obs_t n;
    int   a, b, c, full, sa, sb, ss, nops;
    bit   zs, arith;
    always @(posedge gclk or posedge rst) begin
        if (rst) begin
            m_chain = 0; m_carry = 0; m_zacc = 1;
            for (int i = 1; i <= LAT; i++) exp_line[i] = '{default: 0};
        end else begin
            n = '{default: 0};
            for (int i = LAT; i >= 2; i--) exp_line[i] = exp_line[i-1];
            if (In_valid) begin
                a = Cmpl_X ? 255 - int'(X) : int'(X);
                b = Cmpl_Y ? 255 - int'(Y) : int'(Y);
                c = m_chain ? int'(m_carry) : int'(Carry_in);
                nops = int'(Op_XOR) + int'(Op_AND) + int'(Op_ARITH);
                arith = (nops == 1) && Op_ARITH;
                n.v = 1; n.last = End;
                if (nops == 1 && Op_XOR) n.sum = a ^ b;
                else if (nops == 1 && Op_AND) n.sum = a & b;
                else if (arith) begin
                    full = a + b + c;
                    n.sum = full % 256;
                    n.cout = (full >= 256);
                    if (End) begin
                        sa = (a >= 128) ? a - 256 : a;
                        sb = (b >= 128) ? b - 256 : b;
                        ss = sa + sb + c;
                        n.ovf = (ss > 127) || (ss < -128);
                    end
                end
                zs = m_chain ? m_zacc : 1'b1;
                n.zero = End && zs && (n.sum == 0);
                m_carry = arith ? n.cout : 1'b0;
                m_zacc  = End ? 1'b1 : (zs && (n.sum == 0));
                m_chain = !End;
            end
            exp_line[1] = n;
        end
    end

    always @(negedge gclk) begin
        if (!rst) begin
            chk("model_valid", Out_valid, exp_line[LAT].v);
            if (exp_line[LAT].v && Out_valid) begin
                chk("model_last", Out_last, exp_line[LAT].last);
                chk("model_sum", Sum, exp_line[LAT].sum);
                chk("model_cout", Carry_out, exp_line[LAT].cout);
                chk("model_ovf", Overflow, exp_line[LAT].ovf);
                chk("model_zero", Zero, exp_line[LAT].zero);
            end
            if (cyc < 1024 && lit_on[cyc]) begin
                chk("lit_valid", Out_valid, lit[cyc].v);
                if (lit[cyc].v) begin
                    chk("lit_last", Out_last, lit[cyc].last);
                    chk("lit_sum", Sum, lit[cyc].sum);
                    chk("lit_cout", Carry_out, lit[cyc].cout);
                    chk("lit_ovf", Overflow, lit[cyc].ovf);
                    chk("lit_zero", Zero, lit[cyc].zero);
                end
            end
        end
    end

    task automatic beat(input logic [7:0] x, input logic [7:0] y, input bit cin, input bit en,
                        input bit cx, input bit cy, input bit ox, input bit oa, input bit oar,
                        input bit lon, input bit lv, input int ls, input bit lc, input bit lo,
                        input bit lz);
        X = x; Y = y; Carry_in = cin; End = en; Cmpl_X = cx; Cmpl_Y = cy;
        Op_XOR = ox; Op_AND = oa; Op_ARITH = oar; In_valid = 1'b1;
        if (lon) begin
            lit_on[cyc+LAT] = 1'b1;
            lit[cyc+LAT] = '{v: lv, last: en, sum: ls, cout: lc, ovf: lo, zero: lz};
        end
        @(posedge gclk); #1;
        In_valid = 1'b0;
    endtask

    task automatic idle(input int cycles, input bit lon);
        In_valid = 1'b0;
        repeat (cycles) begin
            if (lon) begin
                lit_on[cyc+LAT] = 1'b1;
                lit[cyc+LAT] = '{default: 0};
            end
            @(posedge gclk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) lit_on[i] = 1'b0;
        #1 rst = 1'b1;
        repeat (2) begin
            @(negedge gclk);
            chk("reset_valid", Out_valid, 0);
            chk("reset_outs", {Out_last, Sum, Carry_out, Overflow, Zero}, 0);
        end
        @(posedge gclk); #1 rst = 1'b0;

        // single ARITH slice with signed overflow
        beat(8'h7F, 8'h01, 0, 1, 0, 0, 0, 0, 1,  1, 1, 8'h80, 0, 1, 0);
        // 16-bit 0x0100 - 0x0001, back-to-back slices
        beat(8'h00, 8'h01, 1, 0, 0, 1, 0, 0, 1,  1, 1, 8'hFF, 0, 0, 0);
        beat(8'h01, 8'h00, 1, 1, 0, 1, 0, 0, 1,  1, 1, 8'h00, 1, 0, 0);
        // logic beats
        beat(8'hA5, 8'hFF, 0, 1, 0, 0, 1, 0, 0,  1, 1, 8'h5A, 0, 0, 0);
        beat(8'h0F, 8'h3C, 0, 1, 1, 0, 0, 1, 0,  1, 1, 8'h30, 0, 0, 0);
        idle(3, 0);

        // reset mid-stream discards the in-flight beat and stream state
        beat(8'hFF, 8'h01, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(posedge gclk); #1 rst = 1'b0;
        beat(8'hFF, 8'h01, 0, 1, 0, 0, 0, 0, 1,  1, 1, 8'h00, 1, 0, 1);

        // illegal op combination behaves as a tagged no-op
        beat(8'hFF, 8'h0F, 0, 1, 0, 0, 1, 1, 0,  1, 1, 8'h00, 0, 0, 1);

        // gapped stream keeps the carry across idle cycles
        beat(8'hFF, 8'h01, 0, 0, 0, 0, 0, 0, 1,  1, 1, 8'h00, 1, 0, 0);
        idle(3, 1);
        beat(8'h00, 8'h00, 0, 1, 0, 0, 0, 0, 1,  1, 1, 8'h01, 0, 0, 0);
        idle(LAT + 2, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gf_alu_n_pipe.md
Name: gf_alu_n_pipe

Overview:
- Parametrised, word-serial successor of the 1-bit gf ALU slice.
- Each accepted beat processes a WIDTH-bit slice of X/Y through input complement and an XOR/AND/ARITH select.
- Carry chains between consecutive slices of one operand stream; End marks the final slice.
- Results leave through a LAT-stage balanced output pipeline with valid/last tagging. The block feeds the gf datapath where multi-word operands are streamed slice by slice.

Parameters:
- WIDTH, 8, slice width in bits (>=2).
- LAT, 2, input-to-output latency in gclk cycles (>=1); every output path carries exactly LAT registers.

Ports:
- gclk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- In_valid  input  1  slice present this cycle.
- X  input  WIDTH  operand X slice.
- Y  input  WIDTH  operand Y slice.
- Carry_in  input  1  carry into the first slice of a stream.
- End  input  1  this slice is the last of its stream.
- Cmpl_X  input  1  invert X before use.
- Cmpl_Y  input  1  invert Y before use.
- Op_XOR  input  1  select a^b.
- Op_AND  input  1  select a&b.
- Op_ARITH  input  1  select a+b+c.
- Out_valid  output  1  result slice present.
- Out_last  output  1  End of the corresponding input slice.
- Sum  output  WIDTH  result slice.
- Carry_out  output  1  carry out of the slice MSB.
- Overflow  output  1  signed overflow; valid on the last slice only.
- Zero  output  1  whole stream result zero; valid on the last slice only.

Behaviour:
- a = X ^ {WIDTH{Cmpl_X}}; b = Y ^ {WIDTH{Cmpl_Y}}.
- Ops are one-hot:
  - Op_XOR: Sum = a^b.
  - Op_AND: Sum = a&b.
  - Op_ARITH: {Carry_out, Sum} = a + b + c.
- Non-one-hot op (none set, or more than one set) is a no-op: Sum=0, Carry_out=0, Overflow=0; the beat is still tagged valid/last.
- Carry source c:
  - state FIRST: c = Carry_in.
  - state CHAIN: c = carry_q.
- FSM, updated only on In_valid:
  - FIRST -> CHAIN when End=0.
  - CHAIN -> FIRST when End=1.
  - FIRST + End=1 stays FIRST.
  - CHAIN + End=0 stays CHAIN.
  - In_valid=0 holds state, carry_q and zero_acc.
- carry_q: loaded with the slice carry-out on ARITH beats; cleared on logic and no-op beats. Back-to-back slices are supported, with no bubble needed.
- Overflow = carry into bit WIDTH-1 XOR Carry_out, computed on ARITH beats with End=1; 0 on every other beat.
- Zero = (zero_acc & (Sum==0)) on the End beat; 0 on non-last beats.
  - zero_acc is set to 1 at stream start.
  - zero_acc ANDs in (Sum==0) for every slice of the stream.
- Output timing: a beat accepted at edge k appears on all outputs during the cycle after edge k+LAT-1 (LAT cycles). Out_valid is a pure delayed copy of In_valid, so a gap in the input gives a gap in the output.
- Reset (asynchronous, any time):
  - state=FIRST, carry_q=0, zero_acc=1.
  - All pipeline valid bits = 0; all outputs = 0.
  - Beats in flight are discarded.
  - The next valid slice starts a new stream using Carry_in.
- rst deasserting together with In_valid: the beat is accepted as a FIRST slice.

Decomposition:
- Package gf_alu_pkg:
  - op-select encoding constants (OP_XOR, OP_AND, OP_ARITH, OP_NONE).
  - FSM state enum {ST_FIRST, ST_CHAIN}.
  - Function checking one-hot op validity.
- Sub-module gf_alu_slice:
  - combinational WIDTH-bit complement/op/adder core.
  - Outputs: sum, carry-out, carry into MSB.
- Top gf_alu_n_pipe holds the FSM, carry_q, zero_acc and the LAT-deep output pipeline.

Test Plan (WIDTH=8, LAT=2):
- Single ARITH slice X=0x7F, Y=0x01, Carry_in=0, End=1 -> two cycles later Out_valid=1, Sum=0x80, Carry_out=0, Overflow=1, Zero=0, Out_last=1.
- 16-bit subtract 0x0100-0x0001 as two back-to-back slices, Cmpl_Y=1, Carry_in=1:
  - slice0 X=0x00, Y=0x01 -> Sum=0xFF, Carry_out=0.
  - slice1 X=0x01, Y=0x00, End=1 -> Sum=0x00, Carry_out=1, Overflow=0, Zero=0.
- Logic beats:
  - Op_XOR X=0xA5, Y=0xFF -> Sum=0x5A.
  - Op_AND, Cmpl_X=1, X=0x0F, Y=0x3C -> Sum=0x30.
  - Both beats give Carry_out=0, Overflow=0.
- Reset mid-stream:
  - ARITH slice End=0 X=0xFF, Y=0x01, then rst pulse -> Out_valid stays 0.
  - Then X=0xFF, Y=0x01, Carry_in=0, End=1 -> Sum=0x00, Carry_out=1, Zero=1 (stale carry and zero_acc not used).
- Illegal op Op_XOR=Op_AND=1, X=0xFF, Y=0x0F, End=1 -> Sum=0x00, Carry_out=0, Overflow=0, Out_valid=1.
- Gapped stream:
  - slice0 ARITH X=0xFF, Y=0x01, End=0.
  - Three idle cycles.
  - slice1 X=0x00, Y=0x00, End=1 -> slice1 Sum=0x01 (held carry used); Out_valid shows the same three-cycle gap.
